// File: rtl/matrix_display_sched.sv
// Shared 8x8 LED matrix / buzzer scheduler: fixed-priority grant with a minimum
// frame hold, row-by-row scan of the owner's bitmap, and a gated beep divider.
module matrix_display_sched #(
  parameter int ROW_DIV     = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int BEEP_DIV    = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [63:0] bmp0,
  input  logic [63:0] bmp1,
  input  logic [63:0] bmp2,
  input  logic [2:0]  beep_en,
  output logic [7:0]  hang,
  output logic [7:0]  gre,
  output logic        beep,
  output logic [1:0]  grant,
  output logic        frame_done
);

  localparam int DW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [DW-1:0] DWELL_MAX = DW'(ROW_DIV - 1);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_FRAMES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]    r_state;
  logic [1:0]    r_grant;
  logic [2:0]    r_row;
  logic [DW-1:0] r_dwell;
  logic [HW-1:0] r_held;
  logic [7:0]    r_hang;
  logic [7:0]    r_gre;
  logic          r_beep;
  logic [BW-1:0] r_beep_cnt;

  logic [0:0]    w_nxt_state;
  logic [1:0]    w_nxt_grant;
  logic [2:0]    w_nxt_row;
  logic [DW-1:0] w_nxt_dwell;
  logic [HW-1:0] w_nxt_held;
  logic          w_load;
  logic [63:0]   w_nxt_bmp;
  logic          w_owner_req;
  logic          w_owner_beep;
  logic          w_higher_req;
  logic          w_dwell_last;
  logic          w_frame_last;
  logic [HW-1:0] w_held_inc;
  logic          w_grant_chg;

  function automatic logic [1:0] pick_src(input logic [2:0] rq);
    if (rq[0])      return 2'd0;
    else if (rq[1]) return 2'd1;
    else if (rq[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_beep = 1'b0;
    w_higher_req = 1'b0;
    case (r_grant)
      2'd0: begin w_owner_req = req[0]; w_owner_beep = beep_en[0]; end
      2'd1: begin w_owner_req = req[1]; w_owner_beep = beep_en[1]; w_higher_req = req[0]; end
      2'd2: begin w_owner_req = req[2]; w_owner_beep = beep_en[2]; w_higher_req = |req[1:0]; end
      default: ;
    endcase
  end

  assign w_dwell_last = (r_dwell == DWELL_MAX);
  assign w_frame_last = w_dwell_last && (r_row == 3'd7);
  assign w_held_inc   = (r_held == HOLD_SAT) ? HOLD_SAT : r_held + HW'(1);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_row   = r_row;
    w_nxt_dwell = r_dwell;
    w_nxt_held  = r_held;
    w_load      = 1'b0;
    if (r_state == S_IDLE) begin
      if (|req) begin
        w_nxt_state = S_SCAN;
        w_nxt_grant = pick_src(req);
        w_nxt_row   = 3'd0;
        w_nxt_dwell = '0;
        w_nxt_held  = '0;
        w_load      = 1'b1;
      end
    end else if (!w_dwell_last) begin
      w_nxt_dwell = r_dwell + DW'(1);
    end else begin
      // Row 7 wraps to row 0 naturally; the frame boundary only decides ownership.
      w_nxt_dwell = '0;
      w_nxt_row   = r_row + 3'd1;
      w_load      = 1'b1;
      if (r_row == 3'd7) begin
        w_nxt_held = w_held_inc;
        if (!w_owner_req) begin
          w_nxt_held = '0;
          if (|req) begin
            w_nxt_grant = pick_src(req);
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_grant = 2'd3;
            w_load      = 1'b0;
          end
        end else if (w_higher_req && (w_held_inc == HOLD_SAT)) begin
          w_nxt_grant = pick_src(req);
          w_nxt_held  = '0;
        end
      end
    end
  end

  always_comb begin
    case (w_nxt_grant)
      2'd0:    w_nxt_bmp = bmp0;
      2'd1:    w_nxt_bmp = bmp1;
      2'd2:    w_nxt_bmp = bmp2;
      default: w_nxt_bmp = '0;
    endcase
  end

  assign w_grant_chg = (w_nxt_grant != r_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= 2'd3;
      r_row      <= '0;
      r_dwell    <= '0;
      r_held     <= '0;
      r_hang     <= '1;
      r_gre      <= '0;
      r_beep     <= 1'b0;
      r_beep_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_row   <= w_nxt_row;
      r_dwell <= w_nxt_dwell;
      r_held  <= w_nxt_held;
      if (w_load) begin
        r_hang <= ~(8'h80 >> w_nxt_row);
        r_gre  <= w_nxt_bmp[{w_nxt_row, 3'b000} +: 8];
      end else if (w_nxt_state == S_IDLE) begin
        r_hang <= '1;
        r_gre  <= '0;
      end
      if (w_grant_chg || (r_state != S_SCAN) || !w_owner_beep) begin
        r_beep_cnt <= '0;
        r_beep     <= 1'b0;
      end else if (r_beep_cnt == BEEP_MAX) begin
        r_beep_cnt <= '0;
        r_beep     <= ~r_beep;
      end else begin
        r_beep_cnt <= r_beep_cnt + BW'(1);
      end
    end
  end

  assign hang       = r_hang;
  assign gre        = r_gre;
  assign beep       = r_beep;
  assign grant      = r_grant;
  assign frame_done = (r_state == S_SCAN) && w_frame_last;

endmodule

// File: tb/tb_matrix_display_sched.sv
// Bench for matrix_display_sched: scoreboarded expectations keyed to cycle
// offsets from each grant, plus a scan table and multi-cycle corner sequences.
module tb_matrix_display_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  beep_en;
  logic [63:0] bmp0, bmp1, bmp2;
  logic [7:0]  hang, gre;
  logic        beep;
  logic [1:0]  grant;
  logic        frame_done;

  localparam logic [63:0] BMP0  = 64'h0102040810204080;
  localparam logic [63:0] BMP1  = 64'h8877665544332211;
  localparam logic [63:0] BMP1B = 64'hF0E0D0C0B0A09080;
  localparam logic [63:0] BMP2  = 64'h183C66FFDBFF663C;

  localparam logic [4:0] MH = 5'd1, MG = 5'd2, MN = 5'd4, MB = 5'd8, MF = 5'd16;
  localparam logic [4:0] ALL = 5'd31;

  always #5 clk = ~clk;

  matrix_display_sched #(
    .ROW_DIV    (4),
    .HOLD_FRAMES(2),
    .BEEP_DIV   (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bmp0      (bmp0),
    .bmp1      (bmp1),
    .bmp2      (bmp2),
    .beep_en   (beep_en),
    .hang      (hang),
    .gre       (gre),
    .beep      (beep),
    .grant     (grant),
    .frame_done(frame_done)
  );

  typedef struct {
    int         due;
    string      nm;
    logic [4:0] mask;
    logic [7:0] hang;
    logic [7:0] gre;
    logic [1:0] grant;
    logic       beep;
    logic       fd;
  } exp_t;

  typedef struct {
    int         k;
    logic [7:0] hang;
    logic [7:0] gre;
    logic       fd;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  task automatic expect_k(input int k, input string nm, input logic [4:0] mask,
                          input logic [7:0] h, input logic [7:0] g, input logic [1:0] gn,
                          input logic b, input logic f);
    exp_t e;
    e.due = base + k; e.nm = nm; e.mask = mask;
    e.hang = h; e.gre = g; e.grant = gn; e.beep = b; e.fd = f;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.mask[0]) cmp({e.nm, ".hang"},  32'(hang),       32'(e.hang));
      if (e.mask[1]) cmp({e.nm, ".gre"},   32'(gre),        32'(e.gre));
      if (e.mask[2]) cmp({e.nm, ".grant"}, 32'(grant),      32'(e.grant));
      if (e.mask[3]) cmp({e.nm, ".beep"},  32'(beep),       32'(e.beep));
      if (e.mask[4]) cmp({e.nm, ".fd"},    32'(frame_done), 32'(e.fd));
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < base + k) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; beep_en = '0;
    bmp0 = BMP0; bmp1 = BMP1; bmp2 = BMP2;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic start(input logic [2:0] r, input logic [2:0] be);
    req = r; beep_en = be; base = cyc + 1;
  endtask

  initial begin
    vec_t tbl[11];
    tbl[0]  = '{0,  8'h7F, 8'h3C, 1'b0};
    tbl[1]  = '{3,  8'h7F, 8'h3C, 1'b0};
    tbl[2]  = '{4,  8'hBF, 8'h66, 1'b0};
    tbl[3]  = '{11, 8'hDF, 8'hFF, 1'b0};
    tbl[4]  = '{12, 8'hEF, 8'hDB, 1'b0};
    tbl[5]  = '{28, 8'hFE, 8'h18, 1'b0};
    tbl[6]  = '{30, 8'hFE, 8'h18, 1'b0};
    tbl[7]  = '{31, 8'hFE, 8'h18, 1'b1};
    tbl[8]  = '{32, 8'h7F, 8'h3C, 1'b0};
    tbl[9]  = '{63, 8'hFE, 8'h18, 1'b1};
    tbl[10] = '{64, 8'h7F, 8'h3C, 1'b0};

    // Reset / idle state
    do_reset();
    base = cyc;
    expect_k(1, "idle1", ALL, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0);
    expect_k(2, "idle2", ALL, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0);
    run_to(2);

    // Single source scan of the smiley bitmap
    start(3'b100, 3'b000);
    for (int i = 0; i < 11; i++)
      expect_k(tbl[i].k, $sformatf("scan_k%0d", tbl[i].k), ALL,
               tbl[i].hang, tbl[i].gre, 2'd2, 1'b0, tbl[i].fd);
    run_to(64);

    // Hold then preemption by source 0, beep cleared on the grant change
    do_reset();
    start(3'b100, 3'b111);
    expect_k(11, "pre_b11",  MN | MB, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0);
    expect_k(31, "pre_f1",   MN | MF | MH, 8'hFE, 8'h00, 2'd2, 1'b0, 1'b1);
    expect_k(32, "pre_keep", MN | MH | MG | MF, 8'h7F, 8'h3C, 2'd2, 1'b0, 1'b0);
    expect_k(63, "pre_f2",   MN | MF | MB, 8'h00, 8'h00, 2'd2, 1'b1, 1'b1);
    expect_k(64, "pre_sw",   ALL, 8'h7F, 8'h80, 2'd0, 1'b0, 1'b0);
    expect_k(68, "pre_r1",   MN | MH | MG, 8'hBF, 8'h40, 2'd0, 1'b0, 1'b0);
    expect_k(74, "pre_b74",  MB, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    expect_k(75, "pre_b75",  MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(95, "pre_f3",   ALL, 8'hFE, 8'h01, 2'd0, 1'b0, 1'b1);
    run_to(10);
    req = 3'b101;
    run_to(95);

    // Owner drop mid-frame with nothing pending; non-owner beep enables ignored
    do_reset();
    start(3'b010, 3'b101);
    expect_k(0,  "drop_k0",  ALL, 8'h7F, 8'h11, 2'd1, 1'b0, 1'b0);
    expect_k(11, "drop_b",   MB | MN, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0);
    expect_k(20, "drop_mid", MN | MH | MG, 8'hFB, 8'h66, 2'd1, 1'b0, 1'b0);
    expect_k(31, "drop_end", ALL, 8'hFE, 8'h88, 2'd1, 1'b0, 1'b1);
    expect_k(32, "drop_idl", ALL, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0);
    expect_k(40, "drop_stay", ALL, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0);
    run_to(5);
    req = 3'b000;
    run_to(40);

    // Beep enable / disable / re-enable
    do_reset();
    start(3'b100, 3'b100);
    expect_k(10, "bp10", MB, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    expect_k(11, "bp11", MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(21, "bp21", MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(22, "bp22", MB, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    expect_k(33, "bp33", MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(40, "bp40", MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(41, "bp41", MB, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    expect_k(60, "bp60", MB, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    expect_k(61, "bp61", MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(71, "bp71", MB, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
    expect_k(72, "bp72", MB, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    run_to(40);
    beep_en = 3'b000;
    run_to(50);
    beep_en = 3'b100;
    run_to(72);

    // Tie in IDLE, then a bitmap change mid-row
    do_reset();
    start(3'b110, 3'b000);
    expect_k(0,  "tie_k0",  MN | MH | MG, 8'h7F, 8'h11, 2'd1, 1'b0, 1'b0);
    expect_k(4,  "tie_r1",  MH | MG, 8'hBF, 8'h22, 2'd1, 1'b0, 1'b0);
    expect_k(7,  "tie_old", MH | MG, 8'hBF, 8'h22, 2'd1, 1'b0, 1'b0);
    expect_k(8,  "tie_new", MN | MH | MG, 8'hDF, 8'hA0, 2'd1, 1'b0, 1'b0);
    expect_k(31, "tie_end", ALL, 8'hFE, 8'hF0, 2'd1, 1'b0, 1'b1);
    expect_k(32, "tie_f2",  MN | MH | MG, 8'h7F, 8'h80, 2'd1, 1'b0, 1'b0);
    run_to(5);
    bmp1 = BMP1B;
    run_to(32);

    // Owner drop with two higher sources pending: highest wins, hold ignored
    do_reset();
    start(3'b100, 3'b000);
    expect_k(20, "dh_mid", MN, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0);
    expect_k(31, "dh_end", MN | MF, 8'h00, 8'h00, 2'd2, 1'b0, 1'b1);
    expect_k(32, "dh_sw",  ALL, 8'h7F, 8'h80, 2'd0, 1'b0, 1'b0);
    run_to(5);
    req = 3'b011;
    run_to(32);

    // Asynchronous reset while row 3 is shown
    do_reset();
    start(3'b100, 3'b100);
    expect_k(14, "ar_row3", MN | MH | MG | MB, 8'hEF, 8'hDB, 2'd2, 1'b1, 1'b0);
    run_to(14);
    #3;
    rst = 1'b1;
    #1;
    cmp("async.hang",  32'(hang),       32'h0FF);
    cmp("async.gre",   32'(gre),        32'h000);
    cmp("async.grant", 32'(grant),      32'd3);
    cmp("async.beep",  32'(beep),       32'd0);
    cmp("async.fd",    32'(frame_done), 32'd0);
    step();
    rst = 1'b0;
    req = '0;
    step();

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/matrix_display_sched.md
# matrix_display_sched

Scheduler and scan controller for the shared 8x8 green LED matrix and buzzer of the bomb game board. Three display sources (countdown/status, success face, failure face) each present a full 64-bit bitmap, a request and a beep enable. The block grants the matrix to one source under fixed priority with a minimum hold, scans the owner's bitmap row by row onto `hang`/`gre`, and gates the owner's beep through a toggle divider.

## Interface
- `ROW_DIV`, default 4: clk cycles each row is displayed (≥1).
- `HOLD_FRAMES`, default 2: completed frames before a higher-priority source may preempt (≥1).
- `BEEP_DIV`, default 11: clk cycles between beep toggles (≥1).

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  display request per source; bit 0 has the highest priority.
- `bmp0`, `bmp1`, `bmp2`  in  64 each  bitmap per source; bits [8r+7:8r] are row r column data, bit 8r drives `gre[0]`.
- `beep_en`  in  3  beep enable per source.
- `hang`  out  8  row select, active-low one-hot; row r drives `hang = ~(8'b10000000 >> r)`, so row 0 is 01111111.
- `gre`  out  8  green column data for the active row, active-high.
- `beep`  out  1  buzzer square wave.
- `grant`  out  2  current owner 0..2; 3 means none.
- `frame_done`  out  1  one-cycle pulse in the last cycle of every scanned frame.

## Operation
- States:
  - IDLE: `grant`=3, `hang`=FF, `gre`=00, `beep`=0.
  - SCAN: an owner is held.
- IDLE exit: on any edge where `req`≠0, grant the lowest-index requester, set r=0, dwell=0, held=0, and load row 0 of that source's bitmap.
- SCAN counters:
  - dwell counts 0..ROW_DIV-1.
  - On wrap, r advances 0..7 and wraps to 0.
  - `gre` is loaded from the owner's bitmap row for the new r on the same edge.
  - Bitmap changes are visible only at the next row load.
- Frame boundary: last cycle of a frame is r=7 and dwell=ROW_DIV-1. `frame_done`=1 in that cycle. On the following edge:
  - held saturates at HOLD_FRAMES after incrementing.
  - If the owner's `req` is 0, re-arbitrate among pending requests: grant the highest, or go to IDLE if none. Hold is ignored.
  - Else, if a higher-priority `req` is set and held (including the frame just ended) ≥ HOLD_FRAMES, switch to that source.
  - Else keep the owner and start the next frame.
  - Any grant change resets held=0, r=0 and dwell=0, and loads row 0 of the new owner.
- The grant never changes mid-frame. A drop of the owner's request mid-frame still completes the frame.
- Beep:
  - While in SCAN and `beep_en[grant]`=1, a counter runs 0..BEEP_DIV-1 and `beep` toggles on wrap.
  - Otherwise `beep`=0 and the counter is cleared.
  - A grant change clears both the counter and `beep`.

## Timing
- All outputs are registered, except `frame_done`, which is decoded from registered state.
- Reset values: `hang`=FF, `gre`=00, `beep`=0, `grant`=3, `frame_done`=0, all counters 0, state IDLE.
- Reset is asynchronous: asserting it mid-scan blanks the matrix immediately, without waiting for a clk edge.
- Request latency: `req` first high in cycle t (in IDLE) gives `grant`, `hang`=01111111 and row-0 `gre` in cycle t+1.
- Row period is ROW_DIV cycles; frame period is 8·ROW_DIV cycles (32 at defaults).
- Beep half-period is BEEP_DIV cycles; the first toggle comes BEEP_DIV cycles after enable.
- Simultaneous events:
  - Owner drop plus a higher request at a boundary: the highest pending source wins.
  - Requests arriving in the same cycle: the lowest index wins.
  - With HOLD_FRAMES=1, preemption is allowed at every boundary.

## Test plan
- Reset mid-scan: assert `rst` asynchronously while row 3 is displayed -> `hang`=FF, `gre`=00, `beep`=0, `grant`=3 before the next edge.
- Single source: `req`=100, bmp2 = smiley pattern, defaults -> one cycle later `grant`=2; `hang` walks 7F,BF,…,FE with 4 cycles per row; `gre` row 1 = 66, row 7 = 18; `frame_done` pulses every 32 cycles.
- Hold/preemption: source 2 owns; raise `req[0]` in frame 1 -> switch only at the end of frame 2; new `hang`=7F with bmp0 row 0.
- Owner drop: source 1 owns; drop `req[1]` mid-frame with nothing pending -> frame finishes, then IDLE (`hang`=FF, `grant`=3).
- Beep: owner with `beep_en`=1, BEEP_DIV=11 -> `beep` toggles every 11 cycles; clear `beep_en` -> `beep`=0 the next cycle; re-enable -> first toggle 11 cycles later.
- Tie: `req`=110 asserted in the same IDLE cycle -> `grant`=1; later bmp1 changes mid-row appear only at the next row load.
